// File: rtl/dijkstra_pkg.sv
// Shared widths, derived constants, types and helpers for the Dijkstra weights-RAM scheduler.
package dijkstra_pkg;
  localparam int VIRTEX_DWIDTH    = 16;
  localparam int VIRTEX_NUM_WIDTH = 6;
  localparam int PIPE_WIDTH       = 4;
  localparam int MAX_VIRTEX_NUM   = 64;
  localparam int VIRTEX_AWIDTH    = $clog2(MAX_VIRTEX_NUM * MAX_VIRTEX_NUM / PIPE_WIDTH);
  localparam int PIPE_SHIFT       = $clog2(PIPE_WIDTH);
  localparam int ROW_WORDS        = MAX_VIRTEX_NUM / PIPE_WIDTH;
  localparam int ROW_SHIFT        = $clog2(ROW_WORDS);

  localparam logic [VIRTEX_DWIDTH-1:0] INF_WEIGHT = '1;

  typedef logic [VIRTEX_DWIDTH-1:0] weight_t;
  typedef weight_t word_t [PIPE_WIDTH];

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HOST} sched_state_e;

  function automatic logic [VIRTEX_AWIDTH-1:0] word_addr(
    input logic [VIRTEX_NUM_WIDTH-1:0] row,
    input logic [VIRTEX_NUM_WIDTH-1:0] chunk
  );
    return (VIRTEX_AWIDTH'(row) << ROW_SHIFT) | VIRTEX_AWIDTH'(chunk);
  endfunction

  // Number of RAM words holding 'num' weights, rounded up.
  function automatic logic [VIRTEX_NUM_WIDTH-1:0] nchunk_of(input logic [VIRTEX_NUM_WIDTH:0] num);
    logic [VIRTEX_NUM_WIDTH+1:0] s;
    s = {1'b0, num} + (VIRTEX_NUM_WIDTH+2)'(PIPE_WIDTH - 1);
    return VIRTEX_NUM_WIDTH'(s >> PIPE_SHIFT);
  endfunction
endpackage

// File: rtl/dijkstra_wram_sched_if.sv
// Host, fetch and RAM-side signals of the weights-RAM scheduler.
interface dijkstra_wram_sched_if;
  import dijkstra_pkg::*;

  logic                          host_req_i;
  logic                          host_we_i;
  logic [VIRTEX_AWIDTH-1:0]      host_addr_i;
  word_t                         host_wdata_i;
  logic                          host_gnt_o;
  logic                          host_rvalid_o;
  word_t                         host_rdata_o;

  logic                          fetch_start_i;
  logic [VIRTEX_NUM_WIDTH-1:0]   fetch_row_i;
  logic [VIRTEX_NUM_WIDTH:0]     fetch_num_i;
  logic                          fetch_busy_o;
  logic                          fetch_valid_o;
  logic [VIRTEX_NUM_WIDTH-1:0]   fetch_chunk_o;
  logic                          fetch_last_o;
  word_t                         fetch_data_o;
  logic                          fetch_err_o;

  logic                          ram_cs_o;
  logic                          ram_we_o;
  logic [VIRTEX_AWIDTH-1:0]      ram_addr_o;
  word_t                         ram_wdata_o;
  word_t                         ram_rdata_i;

  modport slave (
    input  host_req_i, host_we_i, host_addr_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o,
    input  fetch_start_i, fetch_row_i, fetch_num_i,
    output fetch_busy_o, fetch_valid_o, fetch_chunk_o, fetch_last_o, fetch_data_o, fetch_err_o,
    output ram_cs_o, ram_we_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport master (
    output host_req_i, host_we_i, host_addr_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o,
    output fetch_start_i, fetch_row_i, fetch_num_i,
    input  fetch_busy_o, fetch_valid_o, fetch_chunk_o, fetch_last_o, fetch_data_o, fetch_err_o,
    input  ram_cs_o, ram_we_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i
  );
endinterface

// File: rtl/dijkstra_rr_arb.sv
// Two-requester round-robin arbiter; the last winner of a contested round loses the next tie.
module dijkstra_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  // Only contested rounds move the pointer, so an uncontested grant does not cost a requester its turn.
  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (req_i == 2'b11) begin
      last_q <= gnt_o[1];
    end
  end
endmodule

// File: rtl/dijkstra_wram_sched.sv
// Shares the single-port weights RAM between the host loader and the row fetcher,
// streaming one adjacency row per fetch in PIPE_WIDTH-wide chunks with out-of-range lanes masked.
module dijkstra_wram_sched (
  input  logic                 clk,
  input  logic                 rst,
  dijkstra_wram_sched_if.slave bus
);
  import dijkstra_pkg::*;

  localparam logic [VIRTEX_NUM_WIDTH-1:0] ONE = VIRTEX_NUM_WIDTH'(1);

  sched_state_e                state_q, state_d;
  logic                        pending_q;
  logic [VIRTEX_NUM_WIDTH-1:0] row_q, nchunk_q, chunk_q, chunk_d;
  logic [VIRTEX_NUM_WIDTH:0]   num_q;
  logic                        gnt_q, gnt_d, cs_q, cs_d, we_q, we_d;
  logic [VIRTEX_AWIDTH-1:0]    addr_q, addr_d;
  word_t                       wdata_q, wdata_d;
  logic                        hrvld_q, fvld_q, flast_q, err_q;
  logic [VIRTEX_NUM_WIDTH-1:0] fchunk_q;
  logic [PIPE_WIDTH-1:0]       fmask_q, lane_mask;

  logic                        busy, start_ok, issue_last, decide;
  logic [1:0]                  arb_req, arb_gnt;
  logic [VIRTEX_NUM_WIDTH-1:0] row_e;

  assign busy       = pending_q | fvld_q;
  assign start_ok   = bus.fetch_start_i && !busy
                   && (bus.fetch_num_i != '0)
                   && (bus.fetch_num_i <= (VIRTEX_NUM_WIDTH+1)'(MAX_VIRTEX_NUM))
                   && ({1'b0, bus.fetch_row_i} < bus.fetch_num_i);
  assign issue_last = (state_q == ST_FETCH) && (chunk_q == nchunk_q - ONE);
  // The last burst cycle is also a decision point so a waiting host is granted right after it.
  assign decide     = (state_q == ST_IDLE) || issue_last;
  assign arb_req[0] = decide & bus.host_req_i;
  assign arb_req[1] = (state_q == ST_IDLE) & (pending_q | start_ok);
  assign row_e      = pending_q ? row_q : bus.fetch_row_i;

  dijkstra_rr_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (arb_req),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    for (int i = 0; i < PIPE_WIDTH; i++) begin
      lane_mask[i] = (int'(chunk_q) * PIPE_WIDTH + i) >= int'(num_q);
    end
  end

  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    gnt_d   = 1'b0;
    cs_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '{default: '0};
    case (state_q)
      ST_FETCH: begin
        if (issue_last) begin
          state_d = ST_IDLE;
        end else begin
          cs_d    = 1'b1;
          chunk_d = chunk_q + ONE;
          addr_d  = word_addr(row_q, chunk_q + ONE);
        end
      end
      ST_HOST: state_d = ST_IDLE;
      default: ;
    endcase
    if (arb_gnt[0]) begin
      state_d = ST_HOST;
      gnt_d   = 1'b1;
      cs_d    = 1'b1;
      we_d    = bus.host_we_i;
      addr_d  = bus.host_addr_i;
      if (bus.host_we_i) wdata_d = bus.host_wdata_i;
    end else if (arb_gnt[1]) begin
      state_d = ST_FETCH;
      cs_d    = 1'b1;
      chunk_d = '0;
      addr_d  = word_addr(row_e, '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      row_q     <= '0;
      num_q     <= '0;
      nchunk_q  <= '0;
      chunk_q   <= '0;
      gnt_q     <= 1'b0;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '{default: '0};
      hrvld_q   <= 1'b0;
      fvld_q    <= 1'b0;
      fchunk_q  <= '0;
      flast_q   <= 1'b0;
      fmask_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      chunk_q  <= chunk_d;
      gnt_q    <= gnt_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= bus.fetch_start_i & ~start_ok;
      if (start_ok) begin
        pending_q <= 1'b1;
        row_q     <= bus.fetch_row_i;
        num_q     <= bus.fetch_num_i;
        nchunk_q  <= nchunk_of(bus.fetch_num_i);
      end else if (issue_last) begin
        pending_q <= 1'b0;
      end
      // RAM read latency is one cycle: tag the returning word with what was issued.
      hrvld_q  <= (state_q == ST_HOST) && !we_q;
      fvld_q   <= (state_q == ST_FETCH);
      fchunk_q <= (state_q == ST_FETCH) ? chunk_q : '0;
      flast_q  <= issue_last;
      fmask_q  <= lane_mask;
    end
  end

  assign bus.host_gnt_o    = gnt_q;
  assign bus.host_rvalid_o = hrvld_q;
  assign bus.fetch_busy_o  = busy;
  assign bus.fetch_valid_o = fvld_q;
  assign bus.fetch_chunk_o = fchunk_q;
  assign bus.fetch_last_o  = flast_q;
  assign bus.fetch_err_o   = err_q;
  assign bus.ram_cs_o      = cs_q;
  assign bus.ram_we_o      = we_q;
  assign bus.ram_addr_o    = addr_q;
  assign bus.ram_wdata_o   = wdata_q;

  always_comb begin
    for (int i = 0; i < PIPE_WIDTH; i++) begin
      bus.host_rdata_o[i] = hrvld_q ? bus.ram_rdata_i[i] : '0;
      if (!fvld_q)         bus.fetch_data_o[i] = '0;
      else if (fmask_q[i]) bus.fetch_data_o[i] = INF_WEIGHT;
      else                 bus.fetch_data_o[i] = bus.ram_rdata_i[i];
    end
  end
endmodule
